// File: rtl/serial_pattern_feeder.sv
// Serializes valid/ready parallel words onto the mealy10010 detector input j, one bit per clock.
// Build option: define SERIAL_FEEDER_LSB_FIRST_EN to send in_data[0] first instead of in_data[L-1].
module serial_pattern_feeder #(
    parameter int         WIDTH      = 8,
    parameter int         LEN_W      = 4,
    parameter int         GAP_CYCLES = 0,
    parameter logic       IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic             j,
    output logic             j_valid,
    output logic             j_last,
    output logic             busy
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sh_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               accept;
    logic [LEN_W-1:0]   len_eff;
    logic               first_bit;
    logic [WIDTH-1:0]   rest_bits;
    logic [WIDTH-1:0]   aligned;

    // A new word may also be taken on the final bit of the current one, so the
    // stream continues without a bubble when no gap is configured.
    assign in_ready = rst && ((state == IDLE) ||
                              (GAP_CYCLES == 0 && state == SHIFT && j_last));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        len_eff   = in_len;
        aligned   = in_data;
        first_bit = 1'b0;
        rest_bits = '0;
        if (in_len == '0 || int'(in_len) > WIDTH) begin
            len_eff = LEN_W'(WIDTH);
        end
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        first_bit = in_data[0];
        rest_bits = in_data >> 1;
`else
        // Left-align the word so its bit L-1 sits at the top of the shifter.
        aligned   = in_data << (LEN_W'(WIDTH) - len_eff);
        first_bit = aligned[WIDTH-1];
        rest_bits = aligned << 1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            sh_q    <= '0;
            len_q   <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
            j       <= IDLE_LEVEL;
            j_valid <= 1'b0;
            j_last  <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            sh_q    <= rest_bits;
            len_q   <= len_eff;
            cnt     <= '0;
            j       <= first_bit;
            j_valid <= 1'b1;
            j_last  <= (len_eff == LEN_W'(1));
        end else begin
            case (state)
                SHIFT: begin
                    if (j_last) begin
                        j       <= IDLE_LEVEL;
                        j_valid <= 1'b0;
                        j_last  <= 1'b0;
                        gap_cnt <= '0;
                        // The IDLE cycle before the next accept is itself one
                        // of the idle cycles, so GAP only covers the rest.
                        state   <= (GAP_CYCLES > 1) ? GAP : IDLE;
                    end else begin
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
                        j    <= sh_q[0];
                        sh_q <= sh_q >> 1;
`else
                        j    <= sh_q[WIDTH-1];
                        sh_q <= sh_q << 1;
`endif
                        cnt     <= cnt + LEN_W'(1);
                        j_last  <= (cnt + LEN_W'(1) == len_q - LEN_W'(1));
                    end
                end
                GAP: begin
                    if (int'(gap_cnt) >= GAP_CYCLES - 2) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Directed table-driven bench for serial_pattern_feeder: no-gap and two-cycle-gap instances.
module tb_serial_pattern_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] in_len = '0;

    logic in_ready0, j0, j_valid0, j_last0, busy0;
    logic in_ready1, j1, j_valid1, j_last1, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_pattern_feeder #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_len(in_len),
        .j(j0), .j_valid(j_valid0), .j_last(j_last0), .busy(busy0)
    );

    serial_pattern_feeder #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_len(in_len),
        .j(j1), .j_valid(j_valid1), .j_last(j_last1), .busy(busy1)
    );

    // seq holds the expected emission order, first bit at seq[n-1].
    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic [7:0] seq;
        int         n;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ebit(input vec_t v, input int i);
        return v.seq[v.n-1-i];
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic send_single(input vec_t v, input string tag);
        int w = 0;
        while (!in_ready0 && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_ready"}, in_ready0, 1);
        in_data  = v.data;
        in_len   = v.len;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~v.data;
        in_len   = 4'd1;
        for (int i = 0; i < v.n; i++) begin
            check($sformatf("%s_j%0d", tag, i), j0, ebit(v, i));
            check($sformatf("%s_v%0d", tag, i), j_valid0, 1);
            check($sformatf("%s_last%0d", tag, i), j_last0, (i == v.n - 1));
            tick();
        end
        check({tag, "_idle_j"}, j0, 0);
        check({tag, "_idle_v"}, j_valid0, 0);
        check({tag, "_idle_busy"}, busy0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t a, b, ga, gb;
        logic [4:0] hist;
        int dets, idle, exp_dets;
        logic acc;

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        vecs[0] = '{data: 8'h12, len: 4'd5,  seq: 8'b01001,    n: 5};
        vecs[1] = '{data: 8'hA5, len: 4'd0,  seq: 8'b10100101, n: 8};
        vecs[2] = '{data: 8'hA5, len: 4'd12, seq: 8'b10100101, n: 8};
        vecs[3] = '{data: 8'hA5, len: 4'd8,  seq: 8'b10100101, n: 8};
        vecs[4] = '{data: 8'h3C, len: 4'd4,  seq: 8'b0011,     n: 4};
        vecs[5] = '{data: 8'h02, len: 4'd3,  seq: 8'b010,      n: 3};
        ga      = '{data: 8'h05, len: 4'd3,  seq: 8'b101,      n: 3};
        gb      = '{data: 8'h06, len: 4'd3,  seq: 8'b011,      n: 3};
        exp_dets = 1;
`else
        vecs[0] = '{data: 8'h12, len: 4'd5,  seq: 8'b10010,    n: 5};
        vecs[1] = '{data: 8'hA5, len: 4'd0,  seq: 8'b10100101, n: 8};
        vecs[2] = '{data: 8'hA5, len: 4'd12, seq: 8'b10100101, n: 8};
        vecs[3] = '{data: 8'hA5, len: 4'd8,  seq: 8'b10100101, n: 8};
        vecs[4] = '{data: 8'h3C, len: 4'd4,  seq: 8'b1100,     n: 4};
        vecs[5] = '{data: 8'h02, len: 4'd3,  seq: 8'b010,      n: 3};
        ga      = '{data: 8'h05, len: 4'd3,  seq: 8'b101,      n: 3};
        gb      = '{data: 8'h06, len: 4'd3,  seq: 8'b110,      n: 3};
        exp_dets = 2;
`endif

        // Reset state, including in_ready held low while rst is low.
        tick();
        tick();
        check("rst_j", j0, 0);
        check("rst_valid", j_valid0, 0);
        check("rst_last", j_last0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ready", in_ready0, 0);
        rst = 1'b1;
        #1;
        check("rel_ready", in_ready0, 1);

        // Single words, including length 0 and over-length.
        for (int k = 0; k < 6; k++) begin
            send_single(vecs[k], $sformatf("vec%0d", k));
        end

        // Back-to-back with no bubble; detector model counts 10010 hits.
        do_reset();
        a = vecs[0];
        b = vecs[5];
        hist = '0;
        dets = 0;
        in_data = a.data; in_len = a.len; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < a.n; i++) begin
            check($sformatf("b2b_a_j%0d", i), j0, ebit(a, i));
            check($sformatf("b2b_a_v%0d", i), j_valid0, 1);
            check($sformatf("b2b_a_ready%0d", i), in_ready0, (i == a.n - 1));
            hist = {hist[3:0], j0};
            if (hist == 5'b10010) dets++;
            if (i == a.n - 1) begin
                in_data = b.data; in_len = b.len; in_valid = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < b.n; i++) begin
            check($sformatf("b2b_b_j%0d", i), j0, ebit(b, i));
            check($sformatf("b2b_b_v%0d", i), j_valid0, 1);
            check($sformatf("b2b_b_last%0d", i), j_last0, (i == b.n - 1));
            hist = {hist[3:0], j0};
            if (hist == 5'b10010) dets++;
            tick();
        end
        check("b2b_detections", dets, exp_dets);
        check("b2b_end_valid", j_valid0, 0);

        // Gap of two cycles on dut1; second word held valid from the start.
        do_reset();
        in_data = ga.data; in_len = ga.len; in_valid = 1'b1;
        tick();
        in_data = gb.data; in_len = gb.len;
        for (int i = 0; i < ga.n; i++) begin
            check($sformatf("gap_a_j%0d", i), j1, ebit(ga, i));
            check($sformatf("gap_a_v%0d", i), j_valid1, 1);
            check($sformatf("gap_a_ready%0d", i), in_ready1, 0);
            tick();
        end
        idle = 0;
        while (!j_valid1 && idle < 10) begin
            check($sformatf("gap_ready_idle%0d", idle), in_ready1, !busy1);
            check($sformatf("gap_j_idle%0d", idle), j1, 0);
            acc = in_ready1;
            idle++;
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("gap_idle_cycles", idle, 2);
        for (int i = 0; i < gb.n; i++) begin
            check($sformatf("gap_b_j%0d", i), j1, ebit(gb, i));
            check($sformatf("gap_b_v%0d", i), j_valid1, 1);
            check($sformatf("gap_b_ready%0d", i), in_ready1, 0);
            tick();
        end
        in_valid = 1'b0;

        // Reset mid-word, with a between-edge glitch first.
        do_reset();
        a = vecs[3];
        in_data = a.data; in_len = a.len; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_j0", j0, ebit(a, 0));
        tick();
        check("mid_j1", j0, ebit(a, 1));
        rst = 1'b0;
        #2;
        check("glitch_j", j0, ebit(a, 1));
        check("glitch_v", j_valid0, 1);
        rst = 1'b1;
        tick();
        check("mid_j2", j0, ebit(a, 2));
        check("mid_busy2", busy0, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", in_ready0, 0);
        tick();
        check("mid_rst_j", j0, 0);
        check("mid_rst_v", j_valid0, 0);
        check("mid_rst_last", j_last0, 0);
        check("mid_rst_busy", busy0, 0);
        rst = 1'b1;
        #1;
        send_single(vecs[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
